mdma_pfch_ctxt_ram_arb: RTL and testbench

Controller and two-port arbiter for the prefetch context RAM (PFCH_CTXT_RAM_DEPTH x PFCH_CTXT_RAM_DATA_BITS, ECC-flagged). After reset it zero-initialises every entry. It then shares the RAM's single write port and single read port between two requesters: the context-programming path (requester C) and the prefetch engine (requester P). It routes read data and ECC status back to the requester that issued the read, and it counts and flags ECC events. The block drives the RAM through the RAM interface master modport.

---
 rtl/mdma_pfch_ctxt_ram_arb_if.sv | 25 ++
 rtl/mdma_pfch_ctxt_ram_arb.sv | 177 +++++++++++++++++
 tb/tb_mdma_pfch_ctxt_ram_arb.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdma_pfch_ctxt_ram_arb_if.sv
// Prefetch context RAM port bundle: one write port and one read port with ECC flags.
// The arbiter drives it through master; the RAM (or its model) sits on slave.
interface mdma_pfch_ctxt_ram_arb_if #(
  parameter int AW = 11,
  parameter int DW = 48
) ();
  logic [AW-1:0] wadr;
  logic          wen;
  logic [DW-1:0] wdat;
  logic          ren;
  logic [AW-1:0] radr;
  logic [DW-1:0] rdat;
  logic          rsbe;
  logic          rdbe;

  modport master (
    output wadr, wen, wdat, ren, radr,
    input  rdat, rsbe, rdbe
  );

  modport slave (
    input  wadr, wen, wdat, ren, radr,
    output rdat, rsbe, rdbe
  );
endinterface

// File: rtl/mdma_pfch_ctxt_ram_arb.sv
// Prefetch context RAM controller: zero-fills the RAM after reset, then shares its
// write and read ports between the context path (C) and the prefetch engine (P).
module mdma_pfch_ctxt_ram_arb #(
  parameter int  PFCH_CTXT_RAM_DEPTH     = 2048,
  parameter int  PFCH_CTXT_RAM_DATA_BITS = 48,
  parameter int  RD_LAT                  = 2,
  localparam int AW = $clog2(PFCH_CTXT_RAM_DEPTH),
  localparam int DW = PFCH_CTXT_RAM_DATA_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done_o,
  input  logic                     c_req_i,
  input  logic                     c_wr_i,
  input  logic [AW-1:0]            c_adr_i,
  input  logic [DW-1:0]            c_wdat_i,
  output logic                     c_ack_o,
  output logic                     c_rvld_o,
  output logic [DW-1:0]            c_rdat_o,
  output logic [1:0]               c_rerr_o,
  input  logic                     p_req_i,
  input  logic                     p_wr_i,
  input  logic [AW-1:0]            p_adr_i,
  input  logic [DW-1:0]            p_wdat_i,
  output logic                     p_ack_o,
  output logic                     p_rvld_o,
  output logic [DW-1:0]            p_rdat_o,
  output logic [1:0]               p_rerr_o,
  mdma_pfch_ctxt_ram_arb_if.master ram,
  output logic                     dbe_err_o,
  output logic [15:0]              sbe_cnt_o
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  // The init pointer is one bit wider so it can reach DEPTH, the cycle that waits
  // for the last zero-fill write to land before RUN.
  localparam logic [AW:0] INIT_END = (AW+1)'(PFCH_CTXT_RAM_DEPTH);

  state_e        state_q, state_d;
  logic [AW:0]   ptr_q, ptr_d;
  logic          last_p_q, last_p_d;
  logic          init_wr;

  logic          run, c_win, acc, sel_wr;
  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_wdat;

  logic          wen_q, ren_q, rown_q;
  logic [AW-1:0] wadr_q, radr_q;
  logic [DW-1:0] wdat_q;

  logic [RD_LAT-1:0] vld_q, own_q;
  logic              ret_vld, ret_own;
  logic [15:0]       sbe_cnt_q, sbe_cnt_d;

  // NOTE: every signal driven in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    init_wr = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (ptr_q == INIT_END) begin
          state_d = ST_RUN;
        end else begin
          init_wr = 1'b1;
          ptr_d   = ptr_q + 1'b1;
        end
      end
      ST_RUN: ;
      default: state_d = ST_INIT;
    endcase
  end

  // Round robin on a tie: the requester not granted last wins.
  always_comb begin
    run      = (state_q == ST_RUN) && !rst;
    c_win    = c_req_i && (!p_req_i || last_p_q);
    c_ack_o  = run && c_win;
    p_ack_o  = run && p_req_i && !c_win;
    acc      = c_ack_o || p_ack_o;
    sel_wr   = c_ack_o ? c_wr_i   : p_wr_i;
    sel_adr  = c_ack_o ? c_adr_i  : p_adr_i;
    sel_wdat = c_ack_o ? c_wdat_i : p_wdat_i;
    last_p_d = last_p_q;
    if (p_ack_o) begin
      last_p_d = 1'b1;
    end else if (c_ack_o) begin
      last_p_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, whatever the order of statements.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      ptr_q    <= '0;
      last_p_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      last_p_q <= last_p_d;
    end
  end

  // NOTE: the RAM array itself has no reset; INIT zero-fills it through the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q  <= 1'b0;
      wadr_q <= '0;
      wdat_q <= '0;
      ren_q  <= 1'b0;
      radr_q <= '0;
      rown_q <= 1'b0;
    end else begin
      wen_q  <= init_wr || (acc && sel_wr);
      ren_q  <= acc && !sel_wr;
      rown_q <= p_ack_o;
      if (init_wr) begin
        wadr_q <= ptr_q[AW-1:0];
        wdat_q <= '0;
      end else if (acc && sel_wr) begin
        wadr_q <= sel_adr;
        wdat_q <= sel_wdat;
      end
      if (acc && !sel_wr) begin
        radr_q <= sel_adr;
      end
    end
  end

  assign ram.wen  = wen_q;
  assign ram.wadr = wadr_q;
  assign ram.wdat = wdat_q;
  assign ram.ren  = ren_q;
  assign ram.radr = radr_q;

  // Clearing the valid bits on reset drops reads still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      own_q     <= '0;
      sbe_cnt_q <= '0;
    end else begin
      vld_q[0]  <= ren_q;
      own_q[0]  <= rown_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        own_q[i] <= own_q[i-1];
      end
      sbe_cnt_q <= sbe_cnt_d;
    end
  end

  always_comb begin
    ret_vld   = vld_q[RD_LAT-1];
    ret_own   = own_q[RD_LAT-1];
    c_rvld_o  = ret_vld && !ret_own;
    p_rvld_o  = ret_vld && ret_own;
    c_rdat_o  = c_rvld_o ? ram.rdat : '0;
    p_rdat_o  = p_rvld_o ? ram.rdat : '0;
    c_rerr_o  = c_rvld_o ? {ram.rdbe, ram.rsbe} : 2'b00;
    p_rerr_o  = p_rvld_o ? {ram.rdbe, ram.rsbe} : 2'b00;
    dbe_err_o = ret_vld && ram.rdbe;
    sbe_cnt_d = sbe_cnt_q;
    if (ret_vld && ram.rsbe && !ram.rdbe && (sbe_cnt_q != 16'hFFFF)) begin
      sbe_cnt_d = sbe_cnt_q + 16'd1;
    end
  end

  assign init_done_o = (state_q == ST_RUN);
  assign sbe_cnt_o   = sbe_cnt_q;

endmodule

// File: tb/tb_mdma_pfch_ctxt_ram_arb.sv
// Directed bench for mdma_pfch_ctxt_ram_arb: RAM model with ECC injection on the slave
// side, a scoreboard of expected returns, immediate assertions at every comparison.
module tb_mdma_pfch_ctxt_ram_arb;
  localparam int DEPTH  = 2048;
  localparam int DW     = 48;
  localparam int RD_LAT = 2;
  localparam int AW     = $clog2(DEPTH);

  typedef struct {
    bit            own;
    logic [DW-1:0] dat;
    logic [1:0]    err;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done;
  logic          c_req, c_wr, c_ack, c_rvld;
  logic [AW-1:0] c_adr;
  logic [DW-1:0] c_wdat, c_rdat;
  logic [1:0]    c_rerr;
  logic          p_req, p_wr, p_ack, p_rvld;
  logic [AW-1:0] p_adr;
  logic [DW-1:0] p_wdat, p_rdat;
  logic [1:0]    p_rerr;
  logic          dbe_err;
  logic [15:0]   sbe_cnt;

  exp_t          sb[$];
  logic [DW-1:0] shadow [DEPTH];
  logic [DW-1:0] mem    [DEPTH];
  logic [DW-1:0] rd_dat [RD_LAT];
  logic          rd_sbe [RD_LAT];
  logic          rd_dbe [RD_LAT];

  int n_pass = 0, n_total = 0, cyc = 0;
  int rd_issued = 0, rd_num = 0, sbe_at = 0, dbe_at = 0, dbe_seen = 0;
  bit sbe_all = 1'b0;

  mdma_pfch_ctxt_ram_arb_if #(.AW(AW), .DW(DW)) ram_if ();

  mdma_pfch_ctxt_ram_arb #(
    .PFCH_CTXT_RAM_DEPTH(DEPTH), .PFCH_CTXT_RAM_DATA_BITS(DW), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .init_done_o(init_done),
    .c_req_i(c_req), .c_wr_i(c_wr), .c_adr_i(c_adr), .c_wdat_i(c_wdat),
    .c_ack_o(c_ack), .c_rvld_o(c_rvld), .c_rdat_o(c_rdat), .c_rerr_o(c_rerr),
    .p_req_i(p_req), .p_wr_i(p_wr), .p_adr_i(p_adr), .p_wdat_i(p_wdat),
    .p_ack_o(p_ack), .p_rvld_o(p_rvld), .p_rdat_o(p_rdat), .p_rerr_o(p_rerr),
    .ram(ram_if), .dbe_err_o(dbe_err), .sbe_cnt_o(sbe_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // RAM model; reads are numbered from 1 in issue order so errors can be injected.
  always @(posedge clk) begin
    if (ram_if.wen === 1'b1) mem[ram_if.wadr] <= ram_if.wdat;
    rd_dat[0] <= (ram_if.ren === 1'b1) ? mem[ram_if.radr] : '0;
    rd_sbe[0] <= (ram_if.ren === 1'b1) && (sbe_all || (rd_num + 1 == sbe_at));
    rd_dbe[0] <= (ram_if.ren === 1'b1) && (rd_num + 1 == dbe_at);
    if (ram_if.ren === 1'b1) rd_num <= rd_num + 1;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_dat[i] <= rd_dat[i-1];
      rd_sbe[i] <= rd_sbe[i-1];
      rd_dbe[i] <= rd_dbe[i-1];
    end
  end

  assign ram_if.rdat = rd_dat[RD_LAT-1];
  assign ram_if.rsbe = rd_sbe[RD_LAT-1];
  assign ram_if.rdbe = rd_dbe[RD_LAT-1];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
  endtask

  // Return monitor: every rvld must match the oldest expected return.
  always @(negedge clk) begin
    exp_t e;
    if (dbe_err === 1'b1) dbe_seen++;
    if (c_rvld === 1'b1 || p_rvld === 1'b1) begin
      check("rvld_both", c_rvld & p_rvld, 0);
      if (sb.size() == 0) begin
        check("rvld_unexpected", c_rvld | p_rvld, 0);
      end else begin
        e = sb.pop_front();
        check("rvld_owner", p_rvld, e.own);
        check("rdat", e.own ? p_rdat : c_rdat, e.dat);
        check("rerr", e.own ? p_rerr : c_rerr, e.err);
        check("rvld_cycle", cyc, e.cyc);
        check("dbe_err", dbe_err, e.err[1]);
      end
    end else if (dbe_err !== 1'b0) begin
      check("dbe_without_rvld", dbe_err, 0);
    end
  end

  task automatic note_ack(input bit is_p, input bit wr, input logic [AW-1:0] adr,
                          input logic [DW-1:0] wdat);
    exp_t e;
    if (wr) begin
      shadow[adr] = wdat;
    end else begin
      rd_issued++;
      e.own = is_p;
      e.dat = shadow[adr];
      e.err = {rd_issued == dbe_at, sbe_all || (rd_issued == sbe_at)};
      e.cyc = cyc + 1 + RD_LAT;
      sb.push_back(e);
    end
  endtask

  // One cycle: drive both requesters at the negedge, check the acks, advance.
  task automatic step(input bit cr, input bit cw, input logic [AW-1:0] ca,
                      input logic [DW-1:0] cd, input bit pr, input bit pw,
                      input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                      input bit ec, input bit ep);
    c_req = cr; c_wr = cw; c_adr = ca; c_wdat = cd;
    p_req = pr; p_wr = pw; p_adr = pa; p_wdat = pd;
    #1;
    check("c_ack", c_ack, ec);
    check("p_ack", p_ack, ep);
    if (c_ack === 1'b1) note_ack(1'b0, cw, ca, cd);
    if (p_ack === 1'b1) note_ack(1'b1, pw, pa, pd);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, 0, '0, '0, 0, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    @(negedge clk);
  endtask

  // Entered at the negedge of cycle 0 (first cycle with rst low); C holds a read of
  // entry 7 throughout, which must not be acked before cycle DEPTH+1.
  task automatic init_seq();
    for (int a = 0; a < DEPTH; a++) shadow[a] = '0;
    c_req = 1'b1; c_wr = 1'b0; c_adr = AW'(7); c_wdat = '0;
    for (int k = 0; k <= DEPTH + 1; k++) begin
      #1;
      check("init_wen", ram_if.wen, (k >= 1 && k <= DEPTH));
      if (ram_if.wen === 1'b1) begin
        check("init_wadr", ram_if.wadr, k - 1);
        check("init_wdat", ram_if.wdat, 0);
      end
      check("init_done", init_done, (k >= DEPTH + 1));
      check("init_ack", c_ack, (k == DEPTH + 1));
      if (c_ack === 1'b1) note_ack(1'b0, 1'b0, c_adr, '0);
      @(negedge clk);
    end
    c_req = 1'b0;
  endtask

  task automatic burst(input int n);
    for (int i = 0; i < n; i++) step(1, 0, i[AW-1:0], '0, 0, 0, '0, '0, 1, 0);
    idle();
    drain();
  endtask

  initial begin
    c_req = 0; c_wr = 0; c_adr = '0; c_wdat = '0;
    p_req = 0; p_wr = 0; p_adr = '0; p_wdat = '0;
    repeat (2) @(negedge clk);
    check("rst_init_done", init_done, 0);
    check("rst_c_ack", c_ack, 0);
    check("rst_p_ack", p_ack, 0);
    check("rst_rvld", {c_rvld, p_rvld}, 0);
    check("rst_wen", ram_if.wen, 0);
    check("rst_ren", ram_if.ren, 0);
    check("rst_wadr", ram_if.wadr, 0);
    check("rst_radr", ram_if.radr, 0);
    check("rst_wdat", ram_if.wdat, 0);
    check("rst_dbe_err", dbe_err, 0);
    check("rst_sbe_cnt", sbe_cnt, 0);
    check("rst_rdat", {c_rdat, p_rdat}, 0);
    check("rst_rerr", {c_rerr, p_rerr}, 0);

    rst = 1'b0;
    init_seq();
    drain();

    // C writes entry 5 then reads it back on the next cycle.
    step(1, 1, AW'(5), 48'hABCD_1234_5678, 0, 0, '0, '0, 1, 0);
    step(1, 0, AW'(5), '0, 0, 0, '0, '0, 1, 0);
    // P alone: wins outright and becomes last grant, so C takes the next tie.
    step(0, 0, '0, '0, 1, 1, AW'(9), 48'h1357_9BDF_2468, 0, 1);

    // Both hold reads for six cycles; 3rd return gets an SBE, 5th a DBE.
    sbe_at = rd_issued + 3;
    dbe_at = rd_issued + 5;
    dbe_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 0, AW'(5), '0, 1, 0, AW'(9), '0, (i % 2) == 0, (i % 2) == 1);
    end
    idle();
    drain();
    check("dbe_pulses", dbe_seen, 1);
    check("sbe_cnt_one", sbe_cnt, 16'd1);

    // Every return flagged SBE: reach 0xFFFE, then saturate at 0xFFFF.
    sbe_all = 1'b1;
    burst(32'hFFFE - 1);
    check("sbe_cnt_fffe", sbe_cnt, 16'hFFFE);
    burst(1);
    check("sbe_cnt_ffff", sbe_cnt, 16'hFFFF);
    burst(2);
    check("sbe_cnt_sat", sbe_cnt, 16'hFFFF);
    sbe_all = 1'b0;

    // Reset with two reads in flight: both must be dropped and INIT must restart.
    step(1, 0, AW'(5), '0, 0, 0, '0, '0, 1, 0);
    step(0, 0, '0, '0, 1, 0, AW'(9), '0, 0, 1);
    check("pre_rst_init_done", init_done, 1);
    c_req = 1'b0;
    p_req = 1'b0;
    rst   = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    init_seq();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
